// File: rtl/lfsr_traffic_gen.sv
// Pseudo-random valid/ready traffic source with run modes and an optional in-band
// sequence checker, built only when LFSR_TRAFFIC_CHECK_EN is defined.
module lfsr_traffic_gen #(
    parameter int                  DATA_LEN = 8,
    parameter int                  CNT_LEN  = 16,
    parameter logic [DATA_LEN-1:0] SEED     = {{(DATA_LEN-1){1'b0}}, 1'b1}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          mode,
    input  logic [CNT_LEN-1:0]  burst_len,
    input  logic [CNT_LEN-1:0]  gap_len,
    input  logic [CNT_LEN-1:0]  total_len,
    output logic                valid,
    input  logic                ready,
    output logic [DATA_LEN-1:0] data,
    output logic                busy,
    output logic                done,
    output logic [CNT_LEN-1:0]  sent_cnt,
    input  logic                chk_valid,
    input  logic [DATA_LEN-1:0] chk_data,
    output logic                chk_ready,
    output logic                err,
    output logic [CNT_LEN-1:0]  err_cnt
);
    generate
        if (DATA_LEN < 3 || DATA_LEN > 32) begin : g_bad_width
            $error("lfsr_traffic_gen: DATA_LEN must be in 3..32");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("lfsr_traffic_gen: SEED must be non-zero");
        end
    endgenerate

    // Maximal-length Fibonacci tap masks, bit i set means lfsr[i] feeds the XOR.
    function automatic logic [31:0] tap_mask(input int w);
        case (w)
            3:  tap_mask = 32'h0000_0006;
            4:  tap_mask = 32'h0000_000C;
            5:  tap_mask = 32'h0000_0014;
            6:  tap_mask = 32'h0000_0030;
            7:  tap_mask = 32'h0000_0060;
            8:  tap_mask = 32'h0000_00B8;
            9:  tap_mask = 32'h0000_0110;
            10: tap_mask = 32'h0000_0240;
            11: tap_mask = 32'h0000_0500;
            12: tap_mask = 32'h0000_0829;
            13: tap_mask = 32'h0000_100D;
            14: tap_mask = 32'h0000_2015;
            15: tap_mask = 32'h0000_6000;
            16: tap_mask = 32'h0000_D008;
            17: tap_mask = 32'h0001_2000;
            18: tap_mask = 32'h0002_0400;
            19: tap_mask = 32'h0004_0023;
            20: tap_mask = 32'h0009_0000;
            21: tap_mask = 32'h0014_0000;
            22: tap_mask = 32'h0030_0000;
            23: tap_mask = 32'h0042_0000;
            24: tap_mask = 32'h00E1_0000;
            25: tap_mask = 32'h0120_0000;
            26: tap_mask = 32'h0200_0023;
            27: tap_mask = 32'h0400_0013;
            28: tap_mask = 32'h0900_0000;
            29: tap_mask = 32'h1400_0000;
            30: tap_mask = 32'h2000_0029;
            31: tap_mask = 32'h4800_0000;
            32: tap_mask = 32'h8020_0003;
            default: tap_mask = 32'h0;
        endcase
    endfunction

    localparam logic [DATA_LEN-1:0] TAPS = DATA_LEN'(tap_mask(DATA_LEN));

    function automatic logic [DATA_LEN-1:0] next_lfsr(input logic [DATA_LEN-1:0] v);
        next_lfsr = {v[DATA_LEN-2:0], ^(v & TAPS)};
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

    state_t             state;
    logic [CNT_LEN-1:0] burst_cnt, gap_cnt;
    logic [CNT_LEN-1:0] sent_nxt, burst_nxt, gap_nxt;
    logic               beat, start_go, counted, bursty;

    assign beat      = valid & ready;
    assign start_go  = (state == S_IDLE) & start & ~abort;
    assign counted   = (mode == 2'b10);
    assign bursty    = (mode == 2'b01) && (burst_len != '0);
    assign sent_nxt  = sent_cnt + CNT_LEN'(1);
    assign burst_nxt = burst_cnt + CNT_LEN'(1);
    assign gap_nxt   = gap_cnt + CNT_LEN'(1);
    assign chk_ready = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            valid     <= 1'b0;
            data      <= SEED;
            busy      <= 1'b0;
            done      <= 1'b0;
            sent_cnt  <= '0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_go) begin
                        data      <= SEED;
                        sent_cnt  <= '0;
                        burst_cnt <= '0;
                        gap_cnt   <= '0;
                        if (counted && total_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            valid <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // A beat coinciding with abort is still delivered and counted.
                    if (beat) begin
                        data     <= next_lfsr(data);
                        sent_cnt <= sent_nxt;
                    end
                    if (abort) begin
                        state <= S_IDLE;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else if (beat) begin
                        if (counted) begin
                            if (sent_nxt == total_len) begin
                                state <= S_IDLE;
                                valid <= 1'b0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else if (bursty) begin
                            if (burst_nxt == burst_len) begin
                                burst_cnt <= '0;
                                if (gap_len != '0) begin
                                    state   <= S_GAP;
                                    valid   <= 1'b0;
                                    gap_cnt <= '0;
                                end
                            end else begin
                                burst_cnt <= burst_nxt;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (gap_nxt == gap_len) begin
                        state <= S_RUN;
                        valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_nxt;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LFSR_TRAFFIC_CHECK_EN
    logic [DATA_LEN-1:0] exp_data;

    // No resync: after a mismatch the expected stream keeps free-running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_data <= SEED;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else if (start_go) begin
            exp_data <= SEED;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else if (chk_valid) begin
            exp_data <= next_lfsr(exp_data);
            if (chk_data != exp_data) begin
                err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_LEN'(1);
            end
        end
    end
`else
    logic chk_unused;
    assign chk_unused = ^{chk_valid, chk_data};
    assign err        = 1'b0;
    assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_lfsr_traffic_gen.sv
// Self-checking bench for lfsr_traffic_gen: run-mode vector table plus hand-written
// stall, abort, burst, checker and reset sequences, with a beat scoreboard.
module tb_lfsr_traffic_gen;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, ready = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [CW-1:0] burst_len = '0, gap_len = '0, total_len = '0;
    logic          valid, busy, done, chk_valid, chk_ready, err;
    logic [DW-1:0] data, chk_data;
    logic [CW-1:0] sent_cnt, err_cnt;
    logic          loop_en = 1'b0, corrupt_en = 1'b0, mon_en = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    lfsr_traffic_gen #(.DATA_LEN(DW), .CNT_LEN(CW), .SEED(8'h01)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .burst_len(burst_len), .gap_len(gap_len), .total_len(total_len),
        .valid(valid), .ready(ready), .data(data), .busy(busy), .done(done),
        .sent_cnt(sent_cnt), .chk_valid(chk_valid), .chk_data(chk_data),
        .chk_ready(chk_ready), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Loopback of the source port into the checker, optionally corrupting 8'h04.
    always_comb begin
        chk_valid = loop_en & valid & ready;
        chk_data  = (corrupt_en && data == 8'h04) ? 8'hFF : data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic push_run(input int n);
        logic [7:0] m;
        m = 8'h01;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(m);
            m = model_next(m);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_data"}, data, 8'h01);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_sent"}, sent_cnt, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_errcnt"}, err_cnt, 0);
        check({tag, "_chkrdy"}, chk_ready, 1);
    endtask

    // Scoreboard: every beat pops one expected data word.
    always @(negedge clk) begin
        if (mon_en && rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: beat with data 0x%0h, no expected entry", data);
            end else begin
                check("sb_data", data, exp_q.pop_front());
            end
        end
    end

    typedef struct {
        logic [1:0] mode;
        int         bl, gl, tl, ncyc, beats, dones;
        logic       busy;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int nb, nd;
        logic prev_stall;
        logic [DW-1:0] prev_data;
        logic [7:0] vpat;

        vecs[0] = '{2'd2, 0, 0, 5, 8, 5, 1, 1'b0};
        vecs[1] = '{2'd2, 0, 0, 1, 4, 1, 1, 1'b0};
        vecs[2] = '{2'd2, 0, 0, 0, 3, 0, 1, 1'b0};
        vecs[3] = '{2'd1, 3, 2, 0, 10, 6, 0, 1'b1};
        vecs[4] = '{2'd0, 0, 0, 0, 7, 7, 0, 1'b1};
        vecs[5] = '{2'd3, 0, 0, 0, 4, 4, 0, 1'b1};
        vecs[6] = '{2'd1, 0, 5, 0, 6, 6, 0, 1'b1};
        vecs[7] = '{2'd1, 2, 0, 0, 6, 6, 0, 1'b1};
        vecs[8] = '{2'd1, 1, 1, 0, 6, 3, 0, 1'b1};

        step();
        step();
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table-driven run modes.
        for (int v = 0; v < 9; v++) begin
            mode      = vecs[v].mode;
            burst_len = CW'(vecs[v].bl);
            gap_len   = CW'(vecs[v].gl);
            total_len = CW'(vecs[v].tl);
            push_run(vecs[v].beats);
            mon_en = 1'b1;
            ready  = 1'b1;
            start  = 1'b1;
            step();
            start = 1'b0;
            nb = 0;
            nd = 0;
            for (int i = 0; i < vecs[v].ncyc; i++) begin
                if (valid && ready) nb++;
                if (done) nd++;
                step();
            end
            ready = 1'b0;
            check($sformatf("v%0d_beats", v), nb, vecs[v].beats);
            check($sformatf("v%0d_done", v), nd, vecs[v].dones);
            check($sformatf("v%0d_sent", v), sent_cnt, vecs[v].beats);
            check($sformatf("v%0d_busy", v), busy, vecs[v].busy);
            check($sformatf("v%0d_sb_left", v), exp_q.size(), 0);
            abort = 1'b1;
            step();
            abort = 1'b0;
            step();
            mon_en = 1'b0;
            exp_q.delete();
        end

        // Counted run of 4 with ready 1,0,0,1,...
        mode = 2'd2;
        total_len = 16'd4;
        push_run(4);
        mon_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        nd = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int i = 0; i < 14; i++) begin
            ready = (i % 3 == 0);
            if (prev_stall) check($sformatf("stall_hold_%0d", i), data, prev_data);
            prev_stall = valid && !ready;
            prev_data = data;
            if (done) nd++;
            step();
        end
        ready = 1'b0;
        check("stall_done", nd, 1);
        check("stall_sent", sent_cnt, 4);
        check("stall_busy", busy, 0);
        check("stall_sb_left", exp_q.size(), 0);
        mon_en = 1'b0;
        exp_q.delete();

        // Continuous run, start while busy ignored, abort on the 3rd beat.
        mode = 2'd0;
        push_run(3);
        mon_en = 1'b1;
        ready = 1'b1;
        start = 1'b1;
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_start_sent", sent_cnt, 2);
        check("busy_start_data", data, 8'h04);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_sent", sent_cnt, 3);
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        step();
        check("abort_done_late", done, 0);
        check("abort_sb_left", exp_q.size(), 0);
        mon_en = 1'b0;
        ready = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("startabort_busy", busy, 0);
        check("startabort_valid", valid, 0);
        check("startabort_sent", sent_cnt, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_data", data, 8'h01);
        check("restart_sent", sent_cnt, 0);
        check("restart_valid", valid, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Burst 3 / gap 2 valid pattern; data continues across the gap.
        mode = 2'd1;
        burst_len = 16'd3;
        gap_len = 16'd2;
        push_run(6);
        mon_en = 1'b1;
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        vpat = 8'b1110_0111;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("burst_valid_%0d", i), valid, vpat[7-i]);
            if (i == 5) check("burst_beat4_data", data, 8'h08);
            step();
        end
        ready = 1'b0;
        check("burst_sb_left", exp_q.size(), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        mon_en = 1'b0;
        exp_q.delete();

        // Checker loopback with the 8'h04 beat corrupted.
        mode = 2'd2;
        total_len = 16'd8;
        loop_en = 1'b1;
        corrupt_en = 1'b1;
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("chk_err_early", err, 0);
        repeat (8) step();
`ifdef LFSR_TRAFFIC_CHECK_EN
        check("chk_err", err, 1);
        check("chk_errcnt", err_cnt, 1);
`else
        check("chk_err_off", err, 0);
        check("chk_errcnt_off", err_cnt, 0);
`endif
        check("chk_ready", chk_ready, 1);
        corrupt_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("chk_clr_err", err, 0);
        check("chk_clr_errcnt", err_cnt, 0);
        repeat (10) step();
        check("chk_clean_err", err, 0);
        check("chk_clean_errcnt", err_cnt, 0);
        loop_en = 1'b0;

        // Reset mid-burst, then a zero-length counted run.
        mode = 2'd1;
        burst_len = 16'd3;
        gap_len = 16'd2;
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        mode = 2'd2;
        total_len = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_valid", valid, 0);
        check("zero_busy", busy, 0);
        check("zero_sent", sent_cnt, 0);
        step();
        check("zero_done_once", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
